mips_fetch_unit: RTL and testbench

Parametrised instruction-fetch front end for the MIPS core. It replaces the bare PC register / +4 adder / branch-jump mux chain with a PC sequencer feeding a fetch queue of {pc, instruction} pairs, handshaked to decode. It supports a start/load vector, late redirects from execute (branch/jump resolution), back-pressure from decode and optional fetch-time jump predecode. It sits between the combinational instruction memory and the decode/control stage.

---
 rtl/mips_fetch_unit_if.sv | 41 ++++
 rtl/mips_fetch_unit.sv | 109 ++++++++++
 tb/tb_mips_fetch_unit.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/mips_fetch_unit_if.sv
// rtl/mips_fetch_unit_if.sv - fetch unit bus: imem read port, execute redirect and decode output stream
interface mips_fetch_unit_if #(
  parameter int XLEN     = 32,
  parameter int FQ_DEPTH = 4
);
  localparam int CW = $clog2(FQ_DEPTH + 1);

  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_instr;
  logic [CW-1:0]   fq_count;

  modport master (
    output imem_addr,
    input  imem_rdata,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_pc,
    output out_instr,
    output fq_count
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_pc,
    input  out_instr,
    input  fq_count
  );
endinterface

// File: rtl/mips_fetch_unit.sv
// rtl/mips_fetch_unit.sv - PC sequencer feeding a {pc, instr} fetch queue to decode
// Optional fetch-time J/JAL predecode is enabled by defining FETCH_JUMP_PREDECODE_EN.
module mips_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter int              FQ_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [XLEN-1:0]   start_pc,
  mips_fetch_unit_if.master bus
);
  localparam int CW = $clog2(FQ_DEPTH + 1);
  localparam int PW = $clog2(FQ_DEPTH);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            running_q, running_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [XLEN-1:0] fq_pc_q    [FQ_DEPTH];
  logic [XLEN-1:0] fq_pc_d    [FQ_DEPTH];
  logic [XLEN-1:0] fq_instr_q [FQ_DEPTH];
  logic [XLEN-1:0] fq_instr_d [FQ_DEPTH];

  logic            flush;
  logic            head_valid;
  logic            pop;
  logic            push;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] next_pc;

  always_comb begin
    flush      = start | (bus.redirect_valid & running_q);
    head_valid = (count_q != '0);
    pop        = head_valid & bus.out_ready & ~flush;
    // A full queue may still accept a push when the head leaves on the same edge
    push       = running_q & ((count_q < CW'(FQ_DEPTH)) | pop) & ~flush;
    pc_plus4   = pc_q + XLEN'(4);
    next_pc    = pc_plus4;
`ifdef FETCH_JUMP_PREDECODE_EN
    if (bus.imem_rdata[31:26] == 6'b000010 || bus.imem_rdata[31:26] == 6'b000011) begin
      next_pc = {pc_plus4[XLEN-1:28], bus.imem_rdata[25:0], 2'b00};
    end
`endif

    pc_d       = pc_q;
    running_d  = running_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    fq_pc_d    = fq_pc_q;
    fq_instr_d = fq_instr_q;

    if (start) begin
      pc_d      = start_pc & ~XLEN'(3);
      running_d = 1'b1;
      count_d   = '0;
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
    end else if (flush) begin
      pc_d     = bus.redirect_pc & ~XLEN'(3);
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) begin
        fq_pc_d[wr_ptr_q]    = pc_q;
        fq_instr_d[wr_ptr_q] = bus.imem_rdata;
        wr_ptr_d             = wr_ptr_q + PW'(1);
        pc_d                 = next_pc;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      running_q <= 1'b0;
      count_q   <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      for (int i = 0; i < FQ_DEPTH; i++) begin
        fq_pc_q[i]    <= '0;
        fq_instr_q[i] <= '0;
      end
    end else begin
      pc_q       <= pc_d;
      running_q  <= running_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      fq_pc_q    <= fq_pc_d;
      fq_instr_q <= fq_instr_d;
    end
  end

  // Outputs come only from registers, so decode never sees an imem_rdata/out_ready path
  assign bus.imem_addr = pc_q;
  assign bus.out_valid = head_valid;
  assign bus.out_pc    = head_valid ? fq_pc_q[rd_ptr_q]    : '0;
  assign bus.out_instr = head_valid ? fq_instr_q[rd_ptr_q] : '0;
  assign bus.fq_count  = count_q;
endmodule

// File: tb/tb_mips_fetch_unit.sv
// tb/tb_mips_fetch_unit.sv - directed and randomized check of mips_fetch_unit against a queue model
module tb_mips_fetch_unit;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] start_pc;
  logic        jmode;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_pc;
  logic        m_run;
  logic [31:0] mq_pc[$];
  logic [31:0] mq_in[$];

  mips_fetch_unit_if #(.XLEN(XLEN), .FQ_DEPTH(DEPTH)) bus ();

  mips_fetch_unit #(.XLEN(XLEN), .FQ_DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .start_pc (start_pc),
    .bus      (bus.master)
  );

  always #5 clk = ~clk;

  // Instruction memory image: mostly loads, a JAL every 32 words, a J at 0x100 in jump mode
  function automatic logic [31:0] instr_at(input logic [31:0] a, input logic jm);
    if (jm && a == 32'h100) return 32'h0800_0040;
    if (a[6:2] == 5'h13) return {6'b000011, 18'h0, a[9:2]};
    return {6'b100011, a[27:2]};
  endfunction

  always_comb bus.imem_rdata = instr_at(bus.imem_addr, jmode);

  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] ins);
    logic [31:0] n;
    n = pc + 32'd4;
`ifdef FETCH_JUMP_PREDECODE_EN
    if (ins[31:26] == 6'd2 || ins[31:26] == 6'd3) n = {n[31:28], ins[25:0], 2'b00};
`else
    if (ins == 32'hFFFF_FFFF) n = n + 32'd0;
`endif
    return n;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc  = 32'h0;
    m_run = 1'b0;
    mq_pc.delete();
    mq_in.delete();
  endtask

  task automatic compare_all();
    logic [31:0] exp_pc, exp_in;
    exp_pc = (mq_pc.size() != 0) ? mq_pc[0] : 32'h0;
    exp_in = (mq_in.size() != 0) ? mq_in[0] : 32'h0;
    check("m_imem_addr", 64'(bus.imem_addr), 64'(m_pc));
    check("m_out_valid", 64'(bus.out_valid), 64'(mq_pc.size() != 0));
    check("m_fq_count",  64'(bus.fq_count),  64'(mq_pc.size()));
    check("m_out_pc",    64'(bus.out_pc),    64'(exp_pc));
    check("m_out_instr", 64'(bus.out_instr), 64'(exp_in));
  endtask

  // Called at a falling edge with inputs already set; returns at the next falling edge
  task automatic step();
    logic [31:0] npc, ins;
    logic        nrun, pop, push;
    logic [31:0] qp[$];
    logic [31:0] qi[$];
    qp   = mq_pc;
    qi   = mq_in;
    npc  = m_pc;
    nrun = m_run;
    if (start) begin
      npc  = start_pc & ~32'h3;
      nrun = 1'b1;
      qp.delete();
      qi.delete();
    end else if (bus.redirect_valid && m_run) begin
      npc = bus.redirect_pc & ~32'h3;
      qp.delete();
      qi.delete();
    end else begin
      pop  = (qp.size() != 0) && bus.out_ready;
      push = m_run && (qp.size() < DEPTH || pop);
      if (pop) begin
        void'(qp.pop_front());
        void'(qi.pop_front());
      end
      if (push) begin
        ins = instr_at(m_pc, jmode);
        qp.push_back(m_pc);
        qi.push_back(ins);
        npc = model_next(m_pc, ins);
      end
    end
    @(posedge clk);
    m_pc  = npc;
    m_run = nrun;
    mq_pc = qp;
    mq_in = qi;
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_start(input logic [31:0] spc);
    start    = 1'b1;
    start_pc = spc;
    step();
    start    = 1'b0;
  endtask

  initial begin
    rst_n              = 1'b0;
    start              = 1'b0;
    start_pc           = '0;
    jmode              = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.out_ready      = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_imem_addr", 64'(bus.imem_addr), 64'h0);
    check("rst_out_valid", 64'(bus.out_valid), 64'h0);
    check("rst_out_pc",    64'(bus.out_pc),    64'h0);
    check("rst_out_instr", 64'(bus.out_instr), 64'h0);
    check("rst_fq_count",  64'(bus.fq_count),  64'h0);
    rst_n = 1'b1;
    step();

    // start at 0x100, streaming
    do_start(32'h100);
    check("seq_lat", 64'(bus.out_valid), 64'h0);
    step();
    check("seq0", 64'(bus.out_pc), 64'h100);
    step();
    check("seq1", 64'(bus.out_pc), 64'h104);
    step();
    check("seq2", 64'(bus.out_pc), 64'h108);

    // back-pressure fills queue, then drains in order
    bus.out_ready = 1'b0;
    do_start(32'h100);
    repeat (8) step();
    check("full_count", 64'(bus.fq_count), 64'd4);
    check("full_addr",  64'(bus.imem_addr), 64'h110);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("drain_pc", 64'(bus.out_pc), 64'(32'h100 + 32'(4 * i)));
      step();
    end

    // redirect with 3 entries queued
    bus.out_ready = 1'b0;
    do_start(32'h300);
    repeat (3) step();
    check("redir_pre", 64'(bus.fq_count), 64'd3);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h203;
    step();
    bus.redirect_valid = 1'b0;
    check("redir_cnt", 64'(bus.fq_count), 64'd0);
    step();
    check("redir_pc", 64'(bus.out_pc), 64'h200);

    // start beats redirect
    bus.out_ready      = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h80;
    do_start(32'h40);
    bus.redirect_valid = 1'b0;
    step();
    check("prio_pc", 64'(bus.out_pc), 64'h40);

    // jump at 0x100
    jmode = 1'b1;
    do_start(32'h100);
    step();
    check("jmp_pc0",  64'(bus.out_pc),    64'h100);
    check("jmp_ins0", 64'(bus.out_instr), 64'h0800_0040);
    step();
`ifdef FETCH_JUMP_PREDECODE_EN
    check("jmp_pc1", 64'(bus.out_pc), 64'h100);
`else
    check("jmp_pc1", 64'(bus.out_pc), 64'h104);
`endif
    jmode = 1'b0;

    // address wrap, then asynchronous reset mid-stream
    do_start(32'hFFFF_FFF8);
    step();
    check("wrap0", 64'(bus.out_pc), 64'hFFFF_FFF8);
    step();
    check("wrap1", 64'(bus.out_pc), 64'hFFFF_FFFC);
    step();
    check("wrap2", 64'(bus.out_pc), 64'h0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(bus.out_valid), 64'h0);
    check("arst_addr",  64'(bus.imem_addr), 64'h0);
    check("arst_count", 64'(bus.fq_count),  64'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // randomized traffic against the queue model
    jmode = 1'b1;
    for (int c = 0; c < 600; c++) begin
      start              = ($urandom_range(0, 39) == 0);
      start_pc           = (($urandom_range(0, 3) == 0) ? 32'h100 : $urandom());
      bus.redirect_valid = ($urandom_range(0, 9) == 0);
      bus.redirect_pc    = $urandom();
      bus.out_ready      = ($urandom_range(0, 9) < 7);
      step();
    end
    start              = 1'b0;
    bus.redirect_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
